// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the load/store unit.
//   - RAM capacity in bytes (requests at or above it fault)
//   - RV32I width codes, response cause codes, FSM state encoding
//   - decode_cause(): fault classification for one request
package lsu_pkg;

  localparam logic [31:0] MEM_CAP_BYTE = 32'h0000_1000;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    CAUSE_OK       = 2'd0,
    CAUSE_MISALIGN = 2'd1,
    CAUSE_RANGE    = 2'd2,
    CAUSE_ILLEGAL  = 2'd3
  } cause_e;

  typedef enum logic {
    ST_IDLE      = 1'b0,
    ST_LOAD_WAIT = 1'b1
  } state_e;

  // Priority: illegal width code, then alignment, then address range.
  function automatic cause_e decode_cause(input logic        we,
                                          input logic [2:0]  funct3,
                                          input logic [31:0] addr);
    logic illegal;
    logic misaligned;
    logic out_of_range;
    if (we) illegal = funct3[2] || (funct3 == 3'b011);
    else    illegal = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
    misaligned   = ((funct3[1:0] == 2'b01) && addr[0]) ||
                   ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
    out_of_range = (addr >= MEM_CAP_BYTE);
    if (illegal)           return CAUSE_ILLEGAL;
    else if (misaligned)   return CAUSE_MISALIGN;
    else if (out_of_range) return CAUSE_RANGE;
    else                   return CAUSE_OK;
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// lsu_load_align: picks the addressed byte/halfword/word out of a RAM read
// word and sign- or zero-extends it according to the load width code.
//   rdata   in  32  RAM read word
//   offset  in  2   byte offset of the load within the word
//   funct3  in  3   load width code (LB/LH/LW/LBU/LHU)
//   result  out 32  extended load result
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [31:0] shifted;

  assign shifted = rdata >> {offset, 3'b000};

  always_comb begin
    result = shifted;
    case (funct3)
      F3_B:    result = {{24{shifted[7]}}, shifted[7:0]};
      F3_BU:   result = {24'h0, shifted[7:0]};
      F3_H:    result = {{16{shifted[15]}}, shifted[15:0]};
      F3_HU:   result = {16'h0, shifted[15:0]};
      default: result = shifted;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// lsu: load/store unit between execute and the unified RAM data port.
// Accepts one request at a time, drives RAM address / lane enables /
// replicated store data combinationally in the accept cycle, and returns a
// single-cycle response with the extended load result or a fault cause.
//   clk, rst                      clock, synchronous active-high reset
//   req_valid/req_ready           request handshake
//   req_we, req_funct3            store flag, RV32I width code
//   req_addr, req_wdata           byte address, right-aligned store data
//   resp_valid/rdata/cause        response pulse, load data, fault cause
//   mem_addr/we/wdata, mem_rdata  RAM port (read data registered by RAM)
//
// state        | meaning
// -------------+-------------------------------------------------------
// ST_IDLE      | ready for a request; stores and faults respond from here
// ST_LOAD_WAIT | load issued, RAM read word arrives this cycle
module lsu
  import lsu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic [1:0]  resp_cause,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_we,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  state_e      state_q, state_d;
  logic [1:0]  off_q, off_d;
  logic [2:0]  f3_q, f3_d;
  logic [31:0] addr_q, addr_d;
  logic        resp_valid_d;
  logic [31:0] resp_rdata_d;
  logic [1:0]  resp_cause_d;
  logic        accept;
  cause_e      cause;
  logic [31:0] load_result;

  assign req_ready = (state_q == ST_IDLE);
  // Requests presented while reset is held are ignored so RAM is never written.
  assign accept    = req_valid && req_ready && !rst;
  assign cause     = decode_cause(req_we, req_funct3, req_addr);

  lsu_load_align u_align (
    .rdata  (mem_rdata),
    .offset (off_q),
    .funct3 (f3_q),
    .result (load_result)
  );

  always_comb begin
    state_d      = state_q;
    off_d        = off_q;
    f3_d         = f3_q;
    addr_d       = addr_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = resp_rdata;
    resp_cause_d = resp_cause;
    mem_addr     = addr_q;
    mem_we       = 4'b0000;
    mem_wdata    = req_wdata;

    if (accept) begin
      addr_d   = {req_addr[31:2], 2'b00};
      mem_addr = addr_d;
      case (req_funct3[1:0])
        2'b00:   mem_wdata = {4{req_wdata[7:0]}};
        2'b01:   mem_wdata = {2{req_wdata[15:0]}};
        default: mem_wdata = req_wdata;
      endcase
      if (req_we && (cause == CAUSE_OK)) begin
        case (req_funct3[1:0])
          2'b00:   mem_we = 4'b0001 << req_addr[1:0];
          2'b01:   mem_we = 4'b0011 << req_addr[1:0];
          default: mem_we = 4'b1111;
        endcase
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (req_we || (cause != CAUSE_OK)) begin
            resp_valid_d = 1'b1;
            resp_rdata_d = 32'h0;
            resp_cause_d = cause;
          end else begin
            off_d   = req_addr[1:0];
            f3_d    = req_funct3;
            state_d = ST_LOAD_WAIT;
          end
        end
      end
      ST_LOAD_WAIT: begin
        resp_valid_d = 1'b1;
        resp_rdata_d = load_result;
        resp_cause_d = CAUSE_OK;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      off_q      <= 2'b00;
      f3_q       <= 3'b000;
      addr_q     <= 32'h0;
      resp_valid <= 1'b0;
      resp_rdata <= 32'h0;
      resp_cause <= 2'b00;
    end else begin
      state_q    <= state_d;
      off_q      <= off_d;
      f3_q       <= f3_d;
      addr_q     <= addr_d;
      resp_valid <= resp_valid_d;
      resp_rdata <= resp_rdata_d;
      resp_cause <= resp_cause_d;
    end
  end

endmodule

// File: doc/lsu.md
# lsu

Load/store unit sitting between the execute stage and the data port of the core's unified RAM. It accepts one memory request at a time from execute and generates the RAM's word address, byte-lane write enables and lane-replicated write data. It then takes the RAM's registered read word and returns a byte/halfword/word result, sign- or zero-extended, with fault reporting.

## Interface
- Parameters: none; memory capacity comes from `` `MEM_CAP_BYTE `` in define.vh.
- clk  in  1  single core clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  execute presents a request.
- req_ready  out  1  LSU can accept; transfer when req_valid && req_ready.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I width code: LB 000, LH 001, LW 010, LBU 100, LHU 101, SB 000, SH 001, SW 010.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- resp_valid  out  1  one-cycle pulse; response fields valid.
- resp_rdata  out  32  extended load result; 0 for stores and faults.
- resp_cause  out  2  0 ok, 1 misaligned, 2 out of range, 3 illegal funct3.
- mem_addr  out  32  word address to RAM, {req_addr[31:2], 2'b00}.
- mem_we  out  4  byte-lane write enables to RAM.
- mem_wdata  out  32  lane-replicated store data to RAM.
- mem_rdata  in  32  RAM read word, registered by RAM one clock after address.

## Operation
- States: IDLE, LOAD_WAIT. req_ready = (state == IDLE).
- Decode on accept, with priority illegal > misaligned > out of range:
  - Illegal: load funct3 in {011, 110, 111}; store funct3[2] = 1 or funct3 = 011.
  - Misaligned: half with addr[0] = 1; word with addr[1:0] != 0.
  - Out of range: addr >= `` `MEM_CAP_BYTE ``.
- mem_addr, mem_we and mem_wdata are combinational from req_* in the accept cycle. mem_we = 0 in every cycle without an accepted, fault-free store.
- Store lanes:
  - SB: wdata = {4{wdata[7:0]}}, we = 4'b0001 << addr[1:0].
  - SH: wdata = {2{wdata[15:0]}}, we = 4'b0011 << addr[1:0].
  - SW: we = 4'b1111.
- Store or any fault: state stays IDLE; response registered at the accept edge.
- Fault-free load: latch addr[1:0] and funct3, go to LOAD_WAIT. Next cycle, extract from mem_rdata (byte = rdata >> 8*off), extend per funct3, register the response, return to IDLE.
- Faulting loads and stores never touch memory; resp_rdata = 0.
- mem_addr is held at the last accepted value when idle; the RAM read port is harmless.

## Timing
- Reset values: state IDLE, resp_valid 0, resp_rdata 0, resp_cause 0, latched offset/funct3 0. req_ready = 1 out of reset.
- Store / fault latency: accept at edge T, resp_valid high during cycle T+1. Back-to-back stores at 1 per cycle.
- Load latency: accept at edge T, RAM samples at T, LSU registers result at T+1, resp_valid high during cycle T+2. req_ready low during LOAD_WAIT, so load throughput is 1 per 2 cycles.
- A load accepted right after a store to the same word sees the new data, because the RAM write lands at the store's accept edge.
- resp_valid is a single-cycle pulse. No backpressure on resp; the consumer must take it.
- rst asserted in LOAD_WAIT: the pending load is dropped with no response, state goes to IDLE, and mem_we stays 0 throughout.
- req_valid low in IDLE: no state change, resp_valid 0.

## Structure
- define.vh holds the funct3 width codes, resp_cause codes, and IDLE/LOAD_WAIT state encodings alongside `` `MEM_CAP_BYTE ``.
- One sub-module, lsu_load_align: combinational (rdata, offset, funct3) -> extended 32-bit result.
- Target 150-250 lines total.

## Test plan
- Reset, then SW 0xDEADBEEF to 0x100, then LW 0x100: store resp after 1 cycle with cause 0 and mem_we = 1111; load resp 2 cycles after accept with rdata 0xDEADBEEF.
- Word 0x80FF7F01 at 0x200, then LB/LBU at 0x200..0x203: LB 0x00000001, 0x0000007F, 0xFFFFFFFF, 0xFFFFFF80; LBU 0x01, 0x7F, 0xFF, 0x80.
- SH 0x1234ABCD to 0x202: mem_we = 1100, mem_wdata = 0xABCDABCD. A following LHU 0x202 returns 0x0000ABCD; LH returns 0xFFFFABCD.
- LW 0x101, SH 0x203, and LW at `` `MEM_CAP_BYTE ``:
  - LW 0x101 and SH 0x203 give cause 1; LW at `` `MEM_CAP_BYTE `` gives cause 2.
  - Each has resp latency 1, mem_we 0, rdata 0.
- Illegal funct3: load funct3 011, and store funct3 100 at misaligned address 0x1 -> cause 3 in both cases (illegal outranks misaligned).
- Load accepted, then rst for one cycle during LOAD_WAIT: no resp_valid at all, and req_ready = 1 the cycle after reset deasserts. Back-to-back SB, SB, LW: store resps on consecutive cycles, and LW sees both bytes.
